// File: rtl/serial_mod_checker.sv
// serial_mod_checker
// Tracks (value of the bitstream received so far) mod DIVISOR, one bit per
// accepted cycle, using only shifts, adds and one conditional subtract per
// step. The stream can be MSB-first (Horner: r = 2r + s) or LSB-first
// (r = r + s*w, where w = 2^k mod DIVISOR is carried as an internal weight).
//
// Handshake: a bit is taken on a rising clk edge exactly when s_valid=1 and
// clear=0; there is no back-pressure. With s_valid=0 all state holds and
// start is ignored. start=1 alongside s_valid makes that bit the first bit of
// a new frame. clear=1 returns to the empty-frame state and discards any bit
// offered in the same cycle. reset (async) overrides everything.
module serial_mod_checker #(
  parameter int DIVISOR   = 5,
  parameter bit LSB_FIRST = 1'b0,
  parameter int CW        = 8,
  localparam int RW       = (DIVISOR > 2) ? $clog2(DIVISOR) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          s_valid,
  input  logic          s,
  input  logic          start,
  output logic          y,
  output logic [RW-1:0] residue,
  output logic [CW-1:0] bit_cnt
);

  // Modulus widened to the sum width so comparisons need no extension.
  localparam logic [RW:0]   D_L     = (RW+1)'(DIVISOR);
  // Weight of the first LSB-first bit is 2^0 mod DIVISOR.
  localparam logic [RW-1:0] W_INIT  = (DIVISOR == 1) ? '0 : RW'(1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [RW-1:0] r_residue;
  logic [RW-1:0] r_weight;
  logic [CW-1:0] r_bit_cnt;

  logic [RW-1:0] w_base_r;
  logic [RW-1:0] w_base_w;
  logic [RW:0]   w_t;
  logic [RW:0]   w_u;
  logic [RW-1:0] w_next_r;
  logic [RW-1:0] w_next_w;
  logic [CW-1:0] w_next_cnt;

  // Next residue/weight/count for an accepted bit; start substitutes the
  // fresh-frame base so the first bit of a frame needs no extra cycle.
  always_comb begin
    w_base_r = start ? '0 : r_residue;
    w_base_w = start ? W_INIT : r_weight;

    // Both operands are below DIVISOR, so the sum fits in RW+1 bits and is
    // below 2*DIVISOR: a single conditional subtract reduces it.
    if (LSB_FIRST) begin
      w_t = {1'b0, w_base_r} + (s ? {1'b0, w_base_w} : '0);
    end else begin
      w_t = {w_base_r, s};
    end
    w_next_r = (w_t >= D_L) ? RW'(w_t - D_L) : w_t[RW-1:0];

    // Weight doubles mod DIVISOR per bit; for power-of-two divisors it
    // reaches 0 and stays there, freezing the residue, which is exact.
    w_u      = {w_base_w, 1'b0};
    w_next_w = (w_u >= D_L) ? RW'(w_u - D_L) : w_u[RW-1:0];

    if (start) begin
      w_next_cnt = CW'(1);
    end else if (r_bit_cnt == CNT_MAX) begin
      w_next_cnt = r_bit_cnt;
    end else begin
      w_next_cnt = r_bit_cnt + 1'b1;
    end
  end

  // State registers: reset > clear > accepted bit > hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_residue <= '0;
      r_weight  <= W_INIT;
      r_bit_cnt <= '0;
    end else if (clear) begin
      r_residue <= '0;
      r_weight  <= W_INIT;
      r_bit_cnt <= '0;
    end else if (s_valid) begin
      r_residue <= w_next_r;
      r_weight  <= w_next_w;
      r_bit_cnt <= w_next_cnt;
    end
  end

  // Outputs decode registers only, so y carries no combinational path from inputs.
  assign residue = r_residue;
  assign bit_cnt = r_bit_cnt;
  assign y       = (r_residue == '0);

endmodule
